// File: rtl/rx_skp_monitor.sv
// -----------------------------------------------------------------------------
// rx_skp_monitor
// Receive-side SKP ordered set monitor. It parses the descrambled, aligned
// per-lane symbol stream and recognises SKP ordered sets in both encodings:
//   gen=0 : 8b/10b    COM followed by 1..5 SKP symbols
//   gen=1 : 128b/130b block (hdr 01) of 4..20 x 0xAA, 0xE1, then 3 tail symbols
// Each valid SKP OS produces a one-cycle skp_detected pulse with its SKP symbol
// count on skp_len. An illegal SKP OS produces a one-cycle skp_malformed
// pulse. skp_timeout is sticky and sets when the far end has not completed a
// SKP OS within the interval limit for the current gen.
//
// Optional feature macro: SKP_STATS_EN adds a saturating 16-bit count of
// detected SKP OSs on skp_count. Only rst clears it.
//
// Ports
//   clk             clock
//   rst             asynchronous active-low reset
//   gen             1 = high gen (128b/130b), 0 = low gen (8b/10b)
//   rx_valid        symbol qualifier; every other rx_* input is ignored when low
//   rx_data[7:0]    received symbol
//   rx_k            K-character flag (low gen only)
//   rx_block_start  high gen: rx_data is symbol 0 of a block
//   rx_sync_hdr[1:0] high gen sync header, valid with rx_block_start
//   skp_rst         synchronous clear from the LTSSM
//   skp_detected    one-cycle pulse: valid SKP OS completed
//   skp_len[4:0]    SKP symbol count of the completed OS; holds between pulses
//   skp_malformed   one-cycle pulse: SKP OS started but is illegal
//   skp_timeout     sticky: interval limit reached
//   skp_count[15:0] saturating SKP OS count (SKP_STATS_EN only)
// -----------------------------------------------------------------------------
module rx_skp_monitor #(
    parameter int CNT_WIDTH         = 14,
    parameter int GEN1_MAX_INTERVAL = 3076,
    parameter int GEN3_MAX_INTERVAL = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gen,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_k,
    input  logic       rx_block_start,
    input  logic [1:0] rx_sync_hdr,
    input  logic       skp_rst,
    output logic       skp_detected,
    output logic [4:0] skp_len,
    output logic       skp_malformed,
    output logic       skp_timeout
`ifdef SKP_STATS_EN
    ,
    output logic [15:0] skp_count
`endif
);

    localparam logic [7:0] SYM_COM    = 8'hBC;
    localparam logic [7:0] SYM_SKP    = 8'h1C;
    localparam logic [7:0] SYM_G3_SKP = 8'hAA;
    localparam logic [7:0] SYM_G3_END = 8'hE1;
    localparam logic [4:0] G1_MAX_SKP = 5'd5;
    localparam logic [4:0] G3_MAX_SKP = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        G1_SKP,
        G3_SKP,
        G3_TAIL
    } state_t;

    state_t               r_state;
    logic [4:0]           r_n;        // SKP symbols seen in the current OS
    logic [1:0]           r_tail;     // high-gen tail symbols consumed
    logic [CNT_WIDTH-1:0] r_cnt;      // symbols spent in IDLE since last OS
    logic                 r_det;
    logic [4:0]           r_len;
    logic                 r_mal;
    logic                 r_timeout;

    logic                 w_is_com;
    logic                 w_is_skp;
    logic                 w_g3_start;
    logic                 w_abort;
    logic [CNT_WIDTH-1:0] w_limit;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic [4:0]           w_n_inc;

    assign w_is_com   = rx_k && (rx_data == SYM_COM);
    assign w_is_skp   = rx_k && (rx_data == SYM_SKP);
    assign w_g3_start = rx_block_start && (rx_sync_hdr == 2'b01) && (rx_data == SYM_G3_SKP);
    // The state itself records which encoding the open OS belongs to, so a
    // mismatch with the live gen input is exactly a mid-OS mode change.
    assign w_abort    = ((r_state == G1_SKP) && gen) ||
                        (((r_state == G3_SKP) || (r_state == G3_TAIL)) && !gen);
    assign w_limit    = gen ? CNT_WIDTH'(GEN3_MAX_INTERVAL) : CNT_WIDTH'(GEN1_MAX_INTERVAL);
    // One extra bit so the compare against the limit cannot wrap.
    assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_n_inc    = r_n + 5'd1;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_tail    <= '0;
            r_cnt     <= '0;
            r_det     <= 1'b0;
            r_len     <= '0;
            r_mal     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // Pulses default low; only the terminating symbol raises them.
            r_det <= 1'b0;
            r_mal <= 1'b0;

            if (skp_rst) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else if (rx_valid) begin
                if (w_abort) begin
                    r_state <= IDLE;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (r_cnt < w_limit) r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
                            if (w_cnt_inc >= {1'b0, w_limit}) r_timeout <= 1'b1;
                            if (!gen && w_is_com) begin
                                r_state <= G1_SKP;
                                r_n     <= '0;
                            end else if (gen && w_g3_start) begin
                                r_state <= G3_SKP;
                                r_n     <= 5'd1;
                            end
                        end

                        G1_SKP: begin
                            if (w_is_skp) begin
                                if (w_n_inc == G1_MAX_SKP) begin
                                    r_det     <= 1'b1;
                                    r_len     <= w_n_inc;
                                    r_cnt     <= '0;
                                    r_timeout <= 1'b0;
                                    r_state   <= IDLE;
                                end else begin
                                    r_n <= w_n_inc;
                                end
                            end else begin
                                // n=0 means COM opened some other ordered set.
                                if (r_n != 5'd0) begin
                                    r_det     <= 1'b1;
                                    r_len     <= r_n;
                                    r_cnt     <= '0;
                                    r_timeout <= 1'b0;
                                end
                                if (w_is_com) r_n     <= '0;
                                else          r_state <= IDLE;
                            end
                        end

                        G3_SKP: begin
                            if (rx_block_start) begin
                                // Truncated OS; the new block is judged as if from IDLE.
                                r_mal <= 1'b1;
                                if (w_g3_start) r_n     <= 5'd1;
                                else            r_state <= IDLE;
                            end else if (rx_data == SYM_G3_SKP) begin
                                if (r_n == G3_MAX_SKP) begin
                                    r_mal   <= 1'b1;
                                    r_state <= IDLE;
                                end else begin
                                    r_n <= w_n_inc;
                                end
                            end else if ((rx_data == SYM_G3_END) && (r_n[1:0] == 2'b00)) begin
                                // n is never 0 here, so a multiple of 4 means 4..20.
                                r_state <= G3_TAIL;
                                r_tail  <= '0;
                            end else begin
                                r_mal   <= 1'b1;
                                r_state <= IDLE;
                            end
                        end

                        G3_TAIL: begin
                            if (rx_block_start) begin
                                r_mal <= 1'b1;
                                if (w_g3_start) begin
                                    r_state <= G3_SKP;
                                    r_n     <= 5'd1;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end else if (r_tail == 2'd2) begin
                                r_det     <= 1'b1;
                                r_len     <= r_n;
                                r_cnt     <= '0;
                                r_timeout <= 1'b0;
                                r_state   <= IDLE;
                            end else begin
                                r_tail <= r_tail + 2'd1;
                            end
                        end

                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign skp_detected  = r_det;
    assign skp_len       = r_len;
    assign skp_malformed = r_mal;
    assign skp_timeout   = r_timeout;

`ifdef SKP_STATS_EN
    logic [15:0] r_skp_count;

    // Counts each detect pulse as it is presented, so it trails by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skp_count <= '0;
        end else if (r_det && (r_skp_count != 16'hFFFF)) begin
            r_skp_count <= r_skp_count + 16'd1;
        end
    end

    assign skp_count = r_skp_count;
`endif

endmodule

// File: tb/tb_rx_skp_monitor.sv
// -----------------------------------------------------------------------------
// tb_rx_skp_monitor
// Directed stimulus for rx_skp_monitor with a behavioural reference model.
// The model tracks an "open ordered set" record and an interval count and
// derives the expected outputs after every clock edge; a compare process
// checks every output on every falling edge. Directed steps additionally
// pin key results to hand-computed literals. Limits are overridden to 20
// (low gen) and 30 (high gen) so timeouts are reachable quickly.
// -----------------------------------------------------------------------------
module tb_rx_skp_monitor;

    localparam int G1L = 20;
    localparam int G3L = 30;

    logic       clk;
    logic       rst;
    logic       gen;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_k;
    logic       rx_block_start;
    logic [1:0] rx_sync_hdr;
    logic       skp_rst;
    logic       skp_detected;
    logic [4:0] skp_len;
    logic       skp_malformed;
    logic       skp_timeout;
`ifdef SKP_STATS_EN
    logic [15:0] skp_count;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    rx_skp_monitor #(
        .CNT_WIDTH        (14),
        .GEN1_MAX_INTERVAL(G1L),
        .GEN3_MAX_INTERVAL(G3L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gen           (gen),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_k          (rx_k),
        .rx_block_start(rx_block_start),
        .rx_sync_hdr   (rx_sync_hdr),
        .skp_rst       (skp_rst),
        .skp_detected  (skp_detected),
        .skp_len       (skp_len),
        .skp_malformed (skp_malformed),
        .skp_timeout   (skp_timeout)
`ifdef SKP_STATS_EN
        ,
        .skp_count     (skp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        bit open;      // an ordered set is in progress
        bit hi;        // ...and it is a 128b/130b one
        int skps;      // SKP symbols seen so far
        bit tail_ph;   // high gen: 0xE1 seen, consuming tail symbols
        int tail_n;
        int cnt;       // IDLE symbols since last completed OS
        bit det;
        bit mal;
        bit to;
        int len;
        int stats;
    } model_t;

    model_t m;

    function automatic model_t open_if_start(model_t s_in);
        model_t s = s_in;
        if (!gen && rx_k && rx_data == 8'hBC) begin
            s.open = 1; s.hi = 0; s.skps = 0; s.tail_ph = 0;
        end else if (gen && rx_block_start && rx_sync_hdr == 2'b01 && rx_data == 8'hAA) begin
            s.open = 1; s.hi = 1; s.skps = 1; s.tail_ph = 0;
        end
        return s;
    endfunction

    function automatic model_t finish_os(model_t s_in, int len);
        model_t s = s_in;
        s.det = 1; s.len = len; s.cnt = 0; s.to = 0; s.open = 0;
        return s;
    endfunction

    function automatic model_t mal_close(model_t s_in);
        model_t s = s_in;
        s.mal = 1; s.open = 0;
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin : ref_model
        model_t s;
        int     limit;
        if (!rst) begin
            s = '{default: 0};
        end else begin
            s = m;
            if (s.det && s.stats < 65535) s.stats = s.stats + 1;
            s.det = 0;
            s.mal = 0;
            if (skp_rst) begin
                s.open = 0; s.cnt = 0; s.to = 0;
            end else if (rx_valid) begin
                limit = gen ? G3L : G1L;
                if (s.open && (s.hi != gen)) begin
                    s.open = 0;
                end else if (!s.open) begin
                    if (s.cnt < limit) s.cnt = s.cnt + 1;
                    if (s.cnt >= limit) s.to = 1;
                    s = open_if_start(s);
                end else if (!s.hi) begin
                    if (rx_k && rx_data == 8'h1C) begin
                        s.skps = s.skps + 1;
                        if (s.skps == 5) s = finish_os(s, 5);
                    end else begin
                        if (s.skps > 0) s = finish_os(s, s.skps);
                        s.open = 0;
                        s = open_if_start(s);
                    end
                end else if (rx_block_start) begin
                    s = mal_close(s);
                    s = open_if_start(s);
                end else if (!s.tail_ph) begin
                    if (rx_data == 8'hAA) begin
                        if (s.skps == 20) s = mal_close(s);
                        else              s.skps = s.skps + 1;
                    end else if (rx_data == 8'hE1 && (s.skps % 4) == 0) begin
                        s.tail_ph = 1; s.tail_n = 0;
                    end else begin
                        s = mal_close(s);
                    end
                end else begin
                    s.tail_n = s.tail_n + 1;
                    if (s.tail_n == 3) s = finish_os(s, s.skps);
                end
            end
        end
        m <= s;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cmp_det", skp_detected, m.det);
        check("cmp_len", skp_len, m.len);
        check("cmp_mal", skp_malformed, m.mal);
        check("cmp_to", skp_timeout, m.to);
`ifdef SKP_STATS_EN
        check("cmp_count", skp_count, m.stats);
`endif
    end

    // ------------------------------------------------------------ stimulus
    task automatic sym(input bit v, input logic [7:0] d, input bit k, input bit bs,
                       input logic [1:0] hdr, input bit sr);
        rx_valid = v; rx_data = d; rx_k = k; rx_block_start = bs;
        rx_sync_hdr = hdr; skp_rst = sr;
        @(negedge clk);
        rx_valid = 1'b0; rx_block_start = 1'b0; skp_rst = 1'b0;
    endtask

    task automatic lo(input logic [7:0] d, input bit k);
        sym(1'b1, d, k, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic hblk(input logic [7:0] d);
        sym(1'b1, d, 1'b0, 1'b1, 2'b01, 1'b0);
    endtask

    task automatic hsym(input logic [7:0] d);
        sym(1'b1, d, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) sym(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        gen = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; rx_k = 1'b0;
        rx_block_start = 1'b0; rx_sync_hdr = 2'b00; skp_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_det", skp_detected, 0);
        check("rst_len", skp_len, 0);
        check("rst_mal", skp_malformed, 0);
        check("rst_to", skp_timeout, 0);
        rst = 1'b1;
        gap(2);

        // Low gen: COM,SKP,SKP,SKP,D0 -> len 3 after D0.
        lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h1C, 1); lo(8'h1C, 1);
        check("g1_len3_early", skp_detected, 0);
        lo(8'h00, 0);
        check("g1_len3_det", skp_detected, 1);
        check("g1_len3_len", skp_len, 3);
        check("model_len3", m.len, 3);
        gap(1);
        check("g1_len3_single", skp_detected, 0);
        check("g1_len_hold", skp_len, 3);

        // Low gen: COM + 5 SKP completes immediately; extra SKP is ignored.
        lo(8'hBC, 1);
        for (int i = 0; i < 5; i++) lo(8'h1C, 1);
        check("g1_len5_det", skp_detected, 1);
        check("g1_len5_len", skp_len, 5);
        lo(8'h1C, 1);
        check("g1_sixth_skp", skp_detected, 0);
        // COM then a TS1 identifier: silently ignored.
        lo(8'hBC, 1); lo(8'h4A, 0);
        check("g1_ts1_det", skp_detected, 0);
        check("g1_ts1_mal", skp_malformed, 0);

        // High gen: 16 x AA, E1, 3 tail symbols -> len 16.
        gen = 1'b1;
        hblk(8'hAA);
        for (int i = 0; i < 15; i++) hsym(8'hAA);
        hsym(8'hE1); hsym(8'h11); hsym(8'h22);
        check("g3_len16_early", skp_detected, 0);
        hsym(8'h33);
        check("g3_len16_det", skp_detected, 1);
        check("g3_len16_len", skp_len, 16);
        gap(2);
`ifdef SKP_STATS_EN
        check("stats_three", skp_count, 3);
`endif

        // High gen: 6 x AA then E1 -> malformed.
        hblk(8'hAA);
        for (int i = 0; i < 5; i++) hsym(8'hAA);
        hsym(8'hE1);
        check("g3_six_mal", skp_malformed, 1);
        check("g3_six_det", skp_detected, 0);
        check("model_mal", m.mal, 1);

        // High gen: 20 x AA is the largest legal OS.
        hblk(8'hAA);
        for (int i = 0; i < 19; i++) hsym(8'hAA);
        hsym(8'hE1); hsym(8'h01); hsym(8'h02); hsym(8'h03);
        check("g3_len20_det", skp_detected, 1);
        check("g3_len20_len", skp_len, 20);

        // High gen: a 21st AA is malformed.
        hblk(8'hAA);
        for (int i = 0; i < 19; i++) hsym(8'hAA);
        check("g3_20aa_nomal", skp_malformed, 0);
        hsym(8'hAA);
        check("g3_21aa_mal", skp_malformed, 1);

        // High gen: block start mid-OS, new block is a fresh SKP OS (len 4).
        hblk(8'hAA); hsym(8'hAA); hsym(8'hAA);
        hblk(8'hAA);
        check("g3_restart_mal", skp_malformed, 1);
        for (int i = 0; i < 3; i++) hsym(8'hAA);
        hsym(8'hE1); hsym(8'h00); hsym(8'h00); hsym(8'h00);
        check("g3_restart_det", skp_detected, 1);
        check("g3_restart_len", skp_len, 4);
        // Block start of a non-SKP block mid-OS.
        hblk(8'hAA); hsym(8'hAA);
        sym(1'b1, 8'h00, 1'b0, 1'b1, 2'b10, 1'b0);
        check("g3_other_blk_mal", skp_malformed, 1);
        hsym(8'hAA);

        // Low gen timeout: clear interval, then 20 IDLE symbols.
        gen = 1'b0;
        lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h00, 0);
        check("g1_len1_det", skp_detected, 1);
        for (int i = 0; i < 10; i++) lo(8'h00, 0);
        gap(3);
        for (int i = 0; i < 9; i++) lo(8'h00, 0);
        check("to_19", skp_timeout, 0);
        lo(8'h00, 0);
        check("to_20", skp_timeout, 1);
        check("model_to_20", m.to, 1);
        for (int i = 0; i < 3; i++) lo(8'h00, 0);
        check("to_sticky", skp_timeout, 1);
        lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h1C, 1);
        check("to_during_os", skp_timeout, 1);
        lo(8'h00, 0);
        check("to_clear_det", skp_detected, 1);
        check("to_clear_len", skp_len, 2);
        check("to_clear", skp_timeout, 0);

        // skp_rst on the terminating symbol beats completion and clears the counter.
        for (int i = 0; i < 10; i++) lo(8'h00, 0);
        lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h1C, 1);
        sym(1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        check("srst_det", skp_detected, 0);
        check("srst_mal", skp_malformed, 0);
        check("srst_len_hold", skp_len, 2);
        for (int i = 0; i < 19; i++) lo(8'h00, 0);
        check("srst_cnt_19", skp_timeout, 0);
        lo(8'h00, 0);
        check("srst_cnt_20", skp_timeout, 1);
        sym(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        check("srst_to_clear", skp_timeout, 0);

        // Gen toggle mid-OS aborts silently (both directions).
        lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h1C, 1);
        gen = 1'b1;
        hsym(8'hAA);
        check("abort_g1_det", skp_detected, 0);
        gen = 1'b0;
        lo(8'h00, 0);
        check("abort_g1_after", skp_detected, 0);
        gen = 1'b1;
        hblk(8'hAA); hsym(8'hAA);
        gen = 1'b0;
        lo(8'h00, 0);
        check("abort_g3_mal", skp_malformed, 0);
        check("abort_g3_det", skp_detected, 0);

        // Back-to-back low-gen OSs terminated by COM.
        lo(8'hBC, 1); lo(8'h1C, 1);
        lo(8'hBC, 1);
        check("b2b_1_det", skp_detected, 1);
        check("b2b_1_len", skp_len, 1);
        lo(8'h1C, 1); lo(8'h1C, 1);
        lo(8'hBC, 1);
        check("b2b_2_det", skp_detected, 1);
        check("b2b_2_len", skp_len, 2);
        lo(8'h00, 0);
        check("b2b_tail_det", skp_detected, 0);
        gap(2);

`ifdef SKP_STATS_EN
        // Saturation of the statistics counter.
        dut.r_skp_count = 16'hFFFD;
        m.stats = 16'hFFFD;
        for (int j = 0; j < 3; j++) begin
            lo(8'hBC, 1); lo(8'h1C, 1); lo(8'h00, 0);
        end
        gap(2);
        check("stats_sat", skp_count, 16'hFFFF);
`endif

        gap(2);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rx_skp_monitor.md
# rx_skp_monitor

Receive-side SKP ordered set monitor for the LTSSM/MAC RX path: the far-end counterpart of the TX SKP scheduler. It parses the descrambled, aligned per-lane symbol stream and recognises SKP ordered sets in both encodings: 8b/10b for low gens, 128b/130b for high gens. For each valid SKP OS it reports a single-cycle detect pulse with the SKP symbol count, for the elastic buffer and LTSSM. It flags malformed SKP OSs, and it raises a sticky timeout when the far end stops sending SKPs within the allowed interval.

## Interface
Parameters:
- CNT_WIDTH, 14, width of the interval counter.
- GEN1_MAX_INTERVAL, 3076, maximum low-gen symbols between SKP OSs before timeout.
- GEN3_MAX_INTERVAL, 12000, maximum high-gen symbols between SKP OSs before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- gen  in  1  1 = high gen (128b/130b), 0 = low gen (8b/10b).
- rx_valid  in  1  symbol qualifier; all other RX inputs are ignored when low.
- rx_data  in  8  received symbol.
- rx_k  in  1  K-character flag; used only when gen=0.
- rx_block_start  in  1  high gen: rx_data is symbol 0 of a block.
- rx_sync_hdr  in  2  high gen sync header; valid with rx_block_start.
- skp_rst  in  1  LTSSM synchronous clear.
- skp_detected  out  1  one-cycle pulse: valid SKP OS completed.
- skp_len  out  5  SKP symbol count of the completed OS; valid with skp_detected.
- skp_malformed  out  1  one-cycle pulse: SKP OS started but is illegal.
- skp_timeout  out  1  sticky: interval limit reached.
- skp_count  out  16  saturating SKP OS count; present only with SKP_STATS_EN.

## Operation
FSM states: IDLE, G1_SKP, G3_SKP, G3_TAIL. Only cycles with rx_valid=1 advance the FSM or the interval counter.

Low gen (gen=0):
- IDLE: a COM symbol (rx_k=1, 0xBC) moves the FSM to G1_SKP with n=0.
- G1_SKP, SKP symbol (rx_k=1, 0x1C): n++.
- G1_SKP, reaching n=5: complete the OS immediately and return to IDLE.
- G1_SKP, any other symbol with n≥1: complete the OS with len=n. If that symbol is COM, stay in G1_SKP with n=0; otherwise go to IDLE.
- G1_SKP, any other symbol with n=0: this is another ordered set (TS1, etc.). Ignore it silently, with no error. Stay in G1_SKP if the symbol is COM; otherwise go to IDLE.

High gen (gen=1):
- Block start with sync_hdr=01 and rx_data=0xAA: go to G3_SKP with n=1.
- Any other block start: stay in IDLE.
- G3_SKP, 0xAA: n++. A 21st 0xAA is malformed; go to IDLE.
- G3_SKP, 0xE1: if n is in {4,8,12,16,20}, go to G3_TAIL; otherwise malformed, go to IDLE.
- G3_SKP, any other symbol: malformed; go to IDLE.
- G3_TAIL: after exactly 3 further symbols, complete the OS with len=n and go to IDLE.
- rx_block_start while in G3_SKP or G3_TAIL: malformed. That symbol is then re-evaluated as an IDLE block start in the same cycle.

Interval counter and mode changes:
- The counter increments on valid symbols while the FSM is in IDLE.
- It clears on OS completion. It does not clear on a malformed OS.
- When it equals the limit for the current gen, skp_timeout sets and the counter holds.
- skp_timeout clears on the next completed OS or on skp_rst.
- A gen change while the FSM is not in IDLE aborts to IDLE, with no pulse of either kind.
- skp_rst: FSM to IDLE, counter=0, skp_timeout=0, no pulses. skp_rst wins over a simultaneous completion or malformed event. skp_count is not affected.

## Timing
- All outputs reset to 0.
- skp_detected, skp_len and skp_malformed are registered. They assert in the cycle after the terminating symbol is sampled, for exactly one cycle.
- skp_timeout asserts in the cycle after the symbol that makes the counter equal the limit.
- Back-to-back OSs (low-gen COM terminating the previous OS) produce one pulse per OS, with no dead cycle.
- skp_len holds its last value between pulses.

## Configuration
- SKP_STATS_EN defined: the skp_count port and a 16-bit counter are present.
  - The counter increments on every skp_detected and saturates at 0xFFFF.
  - Only rst clears it.
- SKP_STATS_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- gen=0, stream COM,SKP,SKP,SKP,D0 -> one skp_detected pulse with skp_len=3, the cycle after D0; interval counter reads 0.
- gen=0, COM followed by 5 SKPs -> pulse with len=5 the cycle after the 5th SKP. A following SKP symbol causes no further pulse. COM,TS1-symbol -> no pulse, no malformed.
- gen=1, block start hdr=01 with 0xAA ×16, 0xE1, 3 tail symbols -> pulse with len=16 after the 3rd tail symbol. The same block with 0xAA ×6 then 0xE1 -> skp_malformed, no detect.
- gen=0, GEN1_MAX_INTERVAL=20 override, 20 data symbols and no SKP -> skp_timeout=1 and stays high. A following valid SKP OS -> skp_timeout=0 in its detect cycle.
- skp_rst asserted in the same cycle as the terminating symbol -> no pulse; counter=0; timeout=0. A gen toggle mid-OS -> no pulse.
- With SKP_STATS_EN, 3 valid OSs -> skp_count=3. Preload near saturation -> count holds at 0xFFFF.
